// File: rtl/coord_list_collector_if.sv
// coord_list_collector_if: coordinate-entry and memory-write bundle for coord_list_collector
// Inputs to the collector: x_in, y_in, write_en, enterNewCoord, finishInit.
// Outputs from the collector: x_out, y_out, address, mem_wren, count, full, reject, done, hex0..hex2.
// master = stimulus side (drives entry inputs), slave = collector side.
interface coord_list_collector_if #(
  parameter int COORD_W = 8,
  parameter int DEPTH = 256
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic [COORD_W-1:0] x_in, y_in, x_out, y_out;
  logic write_en, enterNewCoord, finishInit;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W:0] count;
  logic mem_wren, full, reject, done;
  logic [3:0] hex0, hex1, hex2;
  modport master (
    output x_in, y_in, write_en, enterNewCoord, finishInit,
    input x_out, y_out, address, mem_wren, count, full, reject, done, hex0, hex1, hex2
  );
  modport slave (
    input x_in, y_in, write_en, enterNewCoord, finishInit,
    output x_out, y_out, address, mem_wren, count, full, reject, done, hex0, hex1, hex2
  );
endinterface

// File: rtl/coord_list_collector.sv
// coord_list_collector: collects button-entered (x,y) pairs into a write-only coordinate memory
// Ports: clk, reset (async, active-high), bus (coord_list_collector_if.slave).
// Each rising edge of enterNewCoord (while write_en) latches x_in/y_in; an in-grid pair with
// room left is written for one cycle at address=count, otherwise reject pulses.
// finishInit ends collection (DONE, left only by reset).
// Optional macro COORD_DEDUP_EN: reject a pair equal to the most recently accepted one.
module coord_list_collector #(
  parameter int COORD_W = 8,
  parameter int DEPTH = 256,
  parameter int GRID_W = 256,
  parameter int GRID_H = 256
) (
  input logic clk,
  input logic reset,
  coord_list_collector_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  typedef enum logic [1:0] {COLLECT, WRITE, DONE} state_t;
  state_t r_state, w_next;
  logic [COORD_W-1:0] r_x, r_y;
  logic [ADDR_W:0] r_count;
  logic [11:0] w_cnt;
  logic r_prev, r_armed, r_reject, r_fin;
  logic w_edge, w_take, w_ok, w_acc, w_full, w_dup;
  // r_armed stays low after reset until enterNewCoord has been seen low, so a button
  // still held through reset release never counts as a fresh press.
  assign w_edge = bus.enterNewCoord & ~r_prev & r_armed;
  assign w_full = r_count == (ADDR_W+1)'(DEPTH);
  assign w_take = (r_state == COLLECT) & w_edge & bus.write_en;
  assign w_ok = (int'(bus.x_in) < GRID_W) & (int'(bus.y_in) < GRID_H) & ~w_full & ~w_dup;
  assign w_acc = w_take & w_ok;
`ifdef COORD_DEDUP_EN
  logic [COORD_W-1:0] r_last_x, r_last_y;
  logic r_has_last;
  assign w_dup = r_has_last & (bus.x_in == r_last_x) & (bus.y_in == r_last_y);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_last_x <= '0;
      r_last_y <= '0;
      r_has_last <= 1'b0;
    end else if (w_acc) begin
      r_last_x <= bus.x_in;
      r_last_y <= bus.y_in;
      r_has_last <= 1'b1;
    end
`else
  assign w_dup = 1'b0;
`endif
  // r_fin remembers a finishInit that arrived with an accepted entry so WRITE completes first.
  always_comb begin
    w_next = r_state;
    if (r_state == COLLECT) w_next = w_acc ? WRITE : bus.finishInit ? DONE : COLLECT;
    else if (r_state == WRITE) w_next = r_fin ? DONE : COLLECT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= COLLECT;
      r_x <= '0;
      r_y <= '0;
      r_count <= '0;
      r_prev <= 1'b0;
      r_armed <= 1'b0;
      r_reject <= 1'b0;
      r_fin <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prev <= bus.enterNewCoord;
      r_armed <= r_armed | ~bus.enterNewCoord;
      r_reject <= w_take & ~w_ok;
      r_fin <= w_acc & bus.finishInit;
      if (w_take) begin
        r_x <= bus.x_in;
        r_y <= bus.y_in;
      end
      if (r_state == WRITE) r_count <= r_count + 1'b1;
    end
  assign w_cnt = 12'(r_count);
  assign bus.x_out = r_x;
  assign bus.y_out = r_y;
  assign bus.count = r_count;
  assign bus.address = r_count[ADDR_W-1:0];
  assign bus.mem_wren = r_state == WRITE;
  assign bus.done = r_state == DONE;
  assign bus.full = w_full;
  assign bus.reject = r_reject;
  assign bus.hex0 = w_cnt[3:0];
  assign bus.hex1 = w_cnt[7:4];
  assign bus.hex2 = w_cnt[11:8];
endmodule

// File: tb/tb_coord_list_collector.sv
// tb_coord_list_collector: directed table-driven bench for coord_list_collector (DEPTH=4, 16x16 grid)
module tb_coord_list_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  coord_list_collector_if #(.COORD_W(8), .DEPTH(4)) bus ();
  coord_list_collector #(.COORD_W(8), .DEPTH(4), .GRID_W(16), .GRID_H(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic wr;
    logic rej;
    logic [1:0] addr;
    logic [2:0] cnt;
    logic full;
  } vec_t;
  vec_t tbl [8];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask
  task automatic enter_once(input logic [7:0] x, input logic [7:0] y);
    bus.x_in = x;
    bus.y_in = y;
    bus.enterNewCoord = 1'b1;
    step();
    bus.enterNewCoord = 1'b0;
    step();
  endtask
  initial begin
    int w;
    tbl[0] = '{8'd3, 8'd5, 1, 0, 2'd0, 3'd1, 0};
    tbl[1] = '{8'd20, 8'd2, 0, 1, 2'd0, 3'd1, 0};
    tbl[2] = '{8'd2, 8'd20, 0, 1, 2'd0, 3'd1, 0};
    tbl[3] = '{8'd15, 8'd15, 1, 0, 2'd1, 3'd2, 0};
    tbl[4] = '{8'd16, 8'd0, 0, 1, 2'd0, 3'd2, 0};
    tbl[5] = '{8'd0, 8'd0, 1, 0, 2'd2, 3'd3, 0};
    tbl[6] = '{8'd9, 8'd4, 1, 0, 2'd3, 3'd4, 1};
    tbl[7] = '{8'd1, 8'd1, 0, 1, 2'd0, 3'd4, 1};
    bus.x_in = '0;
    bus.y_in = '0;
    bus.write_en = 1'b1;
    bus.enterNewCoord = 1'b0;
    bus.finishInit = 1'b0;
    #12;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_xout", int'(bus.x_out), 0);
    chk("rst_yout", int'(bus.y_out), 0);
    chk("rst_addr", int'(bus.address), 0);
    chk("rst_wren", int'(bus.mem_wren), 0);
    chk("rst_reject", int'(bus.reject), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_full", int'(bus.full), 0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      bus.x_in = tbl[i].x;
      bus.y_in = tbl[i].y;
      bus.enterNewCoord = 1'b1;
      step();
      chk($sformatf("v%0d_wren", i), int'(bus.mem_wren), int'(tbl[i].wr));
      chk($sformatf("v%0d_reject", i), int'(bus.reject), int'(tbl[i].rej));
      chk($sformatf("v%0d_xout", i), int'(bus.x_out), int'(tbl[i].x));
      chk($sformatf("v%0d_yout", i), int'(bus.y_out), int'(tbl[i].y));
      if (tbl[i].wr) chk($sformatf("v%0d_addr", i), int'(bus.address), int'(tbl[i].addr));
      bus.enterNewCoord = 1'b0;
      step();
      chk($sformatf("v%0d_wren_off", i), int'(bus.mem_wren), 0);
      chk($sformatf("v%0d_reject_off", i), int'(bus.reject), 0);
      chk($sformatf("v%0d_count", i), int'(bus.count), int'(tbl[i].cnt));
      chk($sformatf("v%0d_full", i), int'(bus.full), int'(tbl[i].full));
      chk($sformatf("v%0d_hex0", i), int'(bus.hex0), int'(tbl[i].cnt));
    end
    // button held through reset release must not count as a press
    bus.enterNewCoord = 1'b1;
    bus.x_in = 8'd1;
    bus.y_in = 8'd2;
    do_reset();
    w = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      w += int'(bus.mem_wren);
    end
    chk("held_reset_writes", w, 0);
    bus.enterNewCoord = 1'b0;
    step();
    bus.enterNewCoord = 1'b1;
    w = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      w += int'(bus.mem_wren);
    end
    chk("held10_writes", w, 1);
    chk("held10_count", int'(bus.count), 1);
    // edge with write_en low is dropped, not deferred
    bus.enterNewCoord = 1'b0;
    bus.write_en = 1'b0;
    step();
    bus.enterNewCoord = 1'b1;
    w = 0;
    step();
    w += int'(bus.mem_wren);
    bus.write_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      w += int'(bus.mem_wren);
    end
    chk("we0_writes", w, 0);
    chk("we0_count", int'(bus.count), 1);
    // finishInit together with an accepted edge: write, then done
    bus.enterNewCoord = 1'b0;
    step();
    bus.x_in = 8'd4;
    bus.y_in = 8'd6;
    bus.enterNewCoord = 1'b1;
    bus.finishInit = 1'b1;
    step();
    chk("fin_wren", int'(bus.mem_wren), 1);
    chk("fin_addr", int'(bus.address), 1);
    chk("fin_done_early", int'(bus.done), 0);
    bus.enterNewCoord = 1'b0;
    bus.finishInit = 1'b0;
    step();
    chk("fin_done", int'(bus.done), 1);
    chk("fin_count", int'(bus.count), 2);
    bus.x_in = 8'd5;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      bus.enterNewCoord = ~bus.enterNewCoord;
      step();
      w += int'(bus.mem_wren) + int'(bus.reject);
    end
    chk("done_ignored", w, 0);
    chk("done_count_hold", int'(bus.count), 2);
    chk("done_xout_hold", int'(bus.x_out), 4);
    chk("done_stays", int'(bus.done), 1);
    // reset in the middle of WRITE
    bus.enterNewCoord = 1'b0;
    do_reset();
    bus.x_in = 8'd2;
    bus.y_in = 8'd3;
    bus.enterNewCoord = 1'b1;
    step();
    chk("midw_wren_before", int'(bus.mem_wren), 1);
    #2 reset = 1'b1;
    #1;
    chk("midw_wren", int'(bus.mem_wren), 0);
    chk("midw_count", int'(bus.count), 0);
    chk("midw_done", int'(bus.done), 0);
    chk("midw_xout", int'(bus.x_out), 0);
    bus.enterNewCoord = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("midw_count_after", int'(bus.count), 0);
    bus.x_in = 8'd8;
    bus.y_in = 8'd9;
    bus.enterNewCoord = 1'b1;
    step();
    chk("midw_collect", int'(bus.mem_wren), 1);
    bus.enterNewCoord = 1'b0;
    step();
    chk("midw_count_new", int'(bus.count), 1);
    // duplicate pair handling
    do_reset();
    enter_once(8'd7, 8'd7);
    enter_once(8'd7, 8'd7);
`ifdef COORD_DEDUP_EN
    chk("dup_count", int'(bus.count), 1);
`else
    chk("dup_count", int'(bus.count), 2);
`endif
    // finishInit alone
    bus.finishInit = 1'b1;
    step();
    chk("fin_alone_done", int'(bus.done), 1);
    chk("fin_alone_wren", int'(bus.mem_wren), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
